// File: rtl/alu_pkg.sv
// Shared opcode definitions for the ripple-carry ALU and its 1-bit slice.
package alu_pkg;

   localparam int unsigned OPCODE_W = 2;

   typedef logic [OPCODE_W-1:0] opcode_t;

   localparam opcode_t OP_ADD = 2'b00;
   localparam opcode_t OP_SUB = 2'b01;
   localparam opcode_t OP_AND = 2'b10;
   localparam opcode_t OP_OR  = 2'b11;

endpackage : alu_pkg

// File: rtl/alu_slice.sv
// Combinational 1-bit ALU cell: full adder / full subtractor / AND / OR.
module alu_slice
   import alu_pkg::*;
(
   input  logic    a,
   input  logic    b,
   input  opcode_t opcode,
   input  logic    cin,
   output logic    result,
   output logic    cout
);

   // cin is borrow-in for SUB; cout is a true borrow-out, not an inverted carry.
   always_comb begin
      result = 1'b0;
      cout   = 1'b0;
      case (opcode)
         OP_ADD: begin
            result = a ^ b ^ cin;
            cout   = (a & b) | (a & cin) | (b & cin);
         end
         OP_SUB: begin
            result = a ^ b ^ cin;
            cout   = (~a & b) | (~a & cin) | (b & cin);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         default: ;
      endcase
   end

endmodule : alu_slice

// File: rtl/alu_rc_reg.sv
// Ripple-carry ALU built from alu_slice cells, with a one-cycle registered
// output stage and valid flop.
module alu_rc_reg
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  opcode_t          opcode,
   input  logic             cin,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             out_valid
);

   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_result;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_valid;

   assign w_carry[0] = cin;

   // Slice i takes carry/borrow from slice i-1; the last slice drives cout.
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_slice
      alu_slice u_slice (
         .a      (a[i]),
         .b      (b[i]),
         .opcode (opcode),
         .cin    (w_carry[i]),
         .result (w_result[i]),
         .cout   (w_carry[i+1])
      );
   end

   // Result/cout load only on valid input so they hold (and never take X) otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result <= '0;
         r_cout   <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_result <= w_result;
            r_cout   <= w_carry[WIDTH];
         end
      end
   end

   assign result    = r_result;
   assign cout      = r_cout;
   assign out_valid = r_valid;

endmodule : alu_rc_reg

// File: tb/tb_alu_rc_reg.sv
// Scoreboard bench for alu_rc_reg at WIDTH=4 and WIDTH=1.
module tb_alu_rc_reg;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       v4_in, cin4, c4, v4;
   logic [3:0] a4, b4, r4;
   logic [1:0] op4;

   logic       v1_in, cin1, c1, v1;
   logic [0:0] a1, b1, r1;
   logic [1:0] op1;

   int checks = 0;
   int failures = 0;

   logic [4:0] q4[$];
   logic [1:0] q1[$];
   logic [4:0] last4 = '0;
   logic [1:0] last1 = '0;

   alu_rc_reg #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4_in), .a(a4), .b(b4), .opcode(op4),
      .cin(cin4), .result(r4), .cout(c4), .out_valid(v4)
   );

   alu_rc_reg #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1_in), .a(a1), .b(b1), .opcode(op1),
      .cin(cin1), .result(r1), .cout(c1), .out_valid(v1)
   );

   // Reference model: returns {cout, result[3:0]} for a w-bit ALU (w <= 4).
   function automatic logic [4:0] model(input int w, input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op, input logic cin);
      logic [5:0] t;
      logic [3:0] m;
      m = 4'((1 << w) - 1);
      case (op)
         2'b00:   t = {2'b00, a & m} + {2'b00, b & m} + 6'(cin);
         2'b01:   t = {2'b00, a & m} - {2'b00, b & m} - 6'(cin);
         2'b10:   t = 6'(a & b & m);
         default: t = 6'((a | b) & m);
      endcase
      return {t[w], t[3:0] & m};
   endfunction

   task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op, input logic cin);
      v4_in = v; a4 = a; b4 = b; op4 = op; cin4 = cin;
      if (v) q4.push_back(model(4, a, b, op, cin));
   endtask

   task automatic drive1(input logic v, input logic a, input logic b,
                         input logic [1:0] op, input logic cin);
      logic [4:0] e;
      v1_in = v; a1 = a; b1 = b; op1 = op; cin1 = cin;
      e = model(1, {3'b000, a}, {3'b000, b}, op, cin);
      if (v) q1.push_back({e[4], e[0]});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive4(1'b1, 4'hF, 4'hF, OP_ADD, 1'b1);
      drive1(1'b1, 1'b1, 1'b1, OP_ADD, 1'b1);
      q4.delete(); q1.delete();
      tick(); tick();
      checks++;
      if ({v4, c4, r4} !== 6'b0) begin
         failures++;
         $display("FAIL reset_w4: got v=%b c=%b r=%b, want all zero", v4, c4, r4);
      end
      checks++;
      if ({v1, c1, r1} !== 3'b0) begin
         failures++;
         $display("FAIL reset_w1: got v=%b c=%b r=%b, want all zero", v1, c1, r1);
      end
      drive4(1'b0, 4'h0, 4'h0, OP_ADD, 1'b0);
      drive1(1'b0, 1'b0, 1'b0, OP_ADD, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_add();
      logic [3:0] ta[3] = '{4'b1001, 4'b1001, 4'b1111};
      logic [3:0] tb[3] = '{4'b0110, 4'b0111, 4'b0000};
      logic       tc[3] = '{1'b0, 1'b0, 1'b1};
      logic [4:0] e;
      for (int i = 0; i < 3; i++) begin
         drive4(1'b1, ta[i], tb[i], OP_ADD, tc[i]);
         tick();
         e = (q4.size() != 0) ? q4.pop_front() : 5'bx;
         last4 = e;
         checks++;
         if ({v4, c4, r4} !== {1'b1, e}) begin
            failures++;
            $display("FAIL add_w4[%0d]: got v=%b c=%b r=%b, want v=1 c=%b r=%b", i, v4, c4, r4, e[4], e[3:0]);
         end
      end
   endtask

   task automatic test_sub();
      logic [3:0] ta[4] = '{4'b1111, 4'b0000, 4'b0101, 4'b0000};
      logic [3:0] tb[4] = '{4'b0000, 4'b0001, 4'b0011, 4'b1111};
      logic       tc[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [4:0] e;
      for (int i = 0; i < 4; i++) begin
         drive4(1'b1, ta[i], tb[i], OP_SUB, tc[i]);
         tick();
         e = (q4.size() != 0) ? q4.pop_front() : 5'bx;
         last4 = e;
         checks++;
         if ({v4, c4, r4} !== {1'b1, e}) begin
            failures++;
            $display("FAIL sub_w4[%0d]: got v=%b c=%b r=%b, want v=1 c=%b r=%b", i, v4, c4, r4, e[4], e[3:0]);
         end
      end
   endtask

   task automatic test_logic();
      logic [3:0] ta[7] = '{4'b1010, 4'b1010, 4'b1111, 4'b0000, 4'b1010, 4'b1010, 4'b0000};
      logic [3:0] tb[7] = '{4'b0101, 4'b1111, 4'b1111, 4'b0000, 4'b0101, 4'b0000, 4'b0000};
      logic [1:0] to[7] = '{OP_AND, OP_AND, OP_AND, OP_AND, OP_OR, OP_OR, OP_OR};
      logic [4:0] e;
      for (int i = 0; i < 7; i++) begin
         drive4(1'b1, ta[i], tb[i], to[i], 1'(i % 2));
         tick();
         e = (q4.size() != 0) ? q4.pop_front() : 5'bx;
         last4 = e;
         checks++;
         if ({v4, c4, r4} !== {1'b1, e}) begin
            failures++;
            $display("FAIL logic_w4[%0d]: got v=%b c=%b r=%b, want v=1 c=%b r=%b", i, v4, c4, r4, e[4], e[3:0]);
         end
      end
   endtask

   task automatic test_width1();
      logic       ta[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic       tb[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [1:0] to[11] = '{OP_ADD, OP_ADD, OP_SUB, OP_AND, OP_AND, OP_AND, OP_AND,
                             OP_OR, OP_OR, OP_OR, OP_OR};
      logic [1:0] e;
      for (int i = 0; i < 11; i++) begin
         drive1(1'b1, ta[i], tb[i], to[i], (i >= 3) ? 1'b1 : 1'b0);
         tick();
         e = (q1.size() != 0) ? q1.pop_front() : 2'bx;
         last1 = e;
         checks++;
         if ({v1, c1, r1} !== {1'b1, e}) begin
            failures++;
            $display("FAIL w1[%0d]: got v=%b c=%b r=%b, want v=1 c=%b r=%b", i, v1, c1, r1, e[1], e[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] e4;
      logic [1:0] e1;
      for (int i = 0; i < 16; i++) begin
         drive4(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
         drive1(1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
         tick();
         e4 = (q4.size() != 0) ? q4.pop_front() : 5'bx;
         e1 = (q1.size() != 0) ? q1.pop_front() : 2'bx;
         last4 = e4;
         last1 = e1;
         checks++;
         if ({v4, c4, r4} !== {1'b1, e4}) begin
            failures++;
            $display("FAIL b2b_w4[%0d]: got v=%b c=%b r=%b, want v=1 c=%b r=%b", i, v4, c4, r4, e4[4], e4[3:0]);
         end
         checks++;
         if ({v1, c1, r1} !== {1'b1, e1}) begin
            failures++;
            $display("FAIL b2b_w1[%0d]: got v=%b c=%b r=%b, want v=1 c=%b r=%b", i, v1, c1, r1, e1[1], e1[0]);
         end
      end
      // Idle cycles with changing operands: outputs must hold, out_valid low.
      for (int i = 0; i < 2; i++) begin
         drive4(1'b0, 4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
         drive1(1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
         tick();
         checks++;
         if ({v4, c4, r4} !== {1'b0, last4}) begin
            failures++;
            $display("FAIL hold_w4[%0d]: got v=%b c=%b r=%b, want v=0 c=%b r=%b", i, v4, c4, r4, last4[4], last4[3:0]);
         end
         checks++;
         if ({v1, c1, r1} !== {1'b0, last1}) begin
            failures++;
            $display("FAIL hold_w1[%0d]: got v=%b c=%b r=%b, want v=0 c=%b r=%b", i, v1, c1, r1, last1[1], last1[0]);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [4:0] e;
      drive4(1'b1, 4'b1001, 4'b0111, OP_ADD, 1'b0);
      tick();
      e = (q4.size() != 0) ? q4.pop_front() : 5'bx;
      checks++;
      if ({v4, c4, r4} !== {1'b1, e}) begin
         failures++;
         $display("FAIL pre_reset: got v=%b c=%b r=%b, want v=1 c=%b r=%b", v4, c4, r4, e[4], e[3:0]);
      end
      drive4(1'b1, 4'b1111, 4'b1111, OP_OR, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({v4, c4, r4} !== 6'b0) begin
         failures++;
         $display("FAIL async_reset: got v=%b c=%b r=%b, want all zero", v4, c4, r4);
      end
      q4.delete();
      tick();
      checks++;
      if ({v4, c4, r4} !== 6'b0) begin
         failures++;
         $display("FAIL reset_held: got v=%b c=%b r=%b, want all zero", v4, c4, r4);
      end
      @(negedge clk);
      drive4(1'b1, 4'b0101, 4'b0011, OP_SUB, 1'b1);
      rst_n = 1'b1;
      tick();
      e = (q4.size() != 0) ? q4.pop_front() : 5'bx;
      checks++;
      if ({v4, c4, r4} !== {1'b1, e}) begin
         failures++;
         $display("FAIL post_reset: got v=%b c=%b r=%b, want v=1 c=%b r=%b", v4, c4, r4, e[4], e[3:0]);
      end
      drive4(1'b0, 4'h0, 4'h0, OP_ADD, 1'b0);
      drive1(1'b0, 1'b0, 1'b0, OP_ADD, 1'b0);
      tick();
   endtask

   initial begin
      v4_in = 1'b0; a4 = '0; b4 = '0; op4 = OP_ADD; cin4 = 1'b0;
      v1_in = 1'b0; a1 = '0; b1 = '0; op1 = OP_ADD; cin1 = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_width1();
      test_back_to_back();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_alu_rc_reg

// File: doc/alu_rc_reg.md
Name: alu_rc_reg

Overview:
Parameterised ripple-carry ALU with a registered output stage. It performs add, subtract, bitwise AND and bitwise OR on two WIDTH-bit operands, with a carry/borrow input and output. It is built from 1-bit slices. It replaces the separate 1-bit and 4-bit combinational ALUs: WIDTH=1 and WIDTH=4 are the supported configurations. It sits in the datapath wherever a small integer ALU with one-cycle latency is needed.

Parameters:
WIDTH, 4, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/opcode valid this cycle
a  input  WIDTH  operand A, unsigned
b  input  WIDTH  operand B, unsigned
opcode  input  2  operation select
cin  input  1  carry-in (ADD) / borrow-in (SUB); ignored for AND/OR
result  output  WIDTH  registered result
cout  output  1  registered carry-out (ADD) / borrow-out (SUB); 0 for AND/OR
out_valid  output  1  result/cout valid

Behaviour:
- One clock; reset is asynchronous and active-low.
- While rst_n=0, and immediately on its assertion: result=0, cout=0, out_valid=0.
- Opcode encoding:
  - 2'b00 = ADD: {cout,result} = a + b + cin.
  - 2'b01 = SUB: {borrow,result} = a - b - cin, mod 2^WIDTH. cout=1 iff a < b + cin (unsigned borrow out); cin is borrow-in. This is not the inverted-carry convention.
  - 2'b10 = AND: result = a & b, cout=0.
  - 2'b11 = OR: result = a | b, cout=0.
- Latency is exactly 1 cycle.
  - On each rising clk edge with in_valid=1: result/cout are loaded from the combinational slice chain, and out_valid<=1.
  - On each rising clk edge with in_valid=0: result/cout hold their previous values, and out_valid<=0.
- Full throughput: a new operation may be accepted every cycle. There is no backpressure.
- Carry chain:
  - Slice i receives carry/borrow from slice i-1. Slice 0 receives cin.
  - cout is the carry/borrow out of slice WIDTH-1.
- Wrap-around:
  - ADD overflow sets cout=1 and truncates result (1001+0111, cin 0 -> 0000, cout 1).
  - SUB underflow sets cout=1 and wraps (0000-0001 -> 1111, cout 1).
- cin has no effect on result or cout for AND/OR.
- Reset asserted mid-stream: the in-flight operation is discarded, and outputs go to their reset values asynchronously. The first valid result after release appears one cycle after the first in_valid sampled with rst_n=1.
- No X propagation: outputs are never X after reset, even if inputs are X while in_valid=0.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11;
  - a 2-bit opcode typedef.
- One sub-module, alu_slice: a combinational 1-bit cell.
  - Inputs: a, b, opcode, cin.
  - Outputs: result, cout.
  - ADD: full adder.
  - SUB: full subtractor; result = a^b^cin, cout = (~a&b) | (~a&cin) | (b&cin).
  - AND/OR: cout=0.
- The top generates WIDTH slices in a ripple chain and adds the output register plus valid flop.

Test Plan:
- WIDTH=1, ADD:
  - a=1, b=0, cin=0 -> result=1, cout=0.
  - a=1, b=1, cin=0 -> result=0, cout=1.
  - out_valid=1 one cycle after in_valid.
- WIDTH=4, ADD:
  - 1001+0110, cin 0 -> 1111, cout 0.
  - 1001+0111, cin 0 -> 0000, cout 1.
  - 1111+0000, cin 1 -> 0000, cout 1.
- SUB:
  - WIDTH=1: 1-0, cin 0 -> result=1, cout=0.
  - WIDTH=4: 1111-0000, cin 0 -> 1111, cout 0.
  - WIDTH=4: 0000-0001 -> 1111, cout 1.
  - WIDTH=4: 0101-0011, cin 1 -> 0001, cout 0.
- AND/OR exhaustive for WIDTH=1 (all four a/b pairs, cout always 0). WIDTH=4:
  - AND: 1010&0101=0000, 1010&1111=1010, 1111&1111=1111, 0000&0000=0000.
  - OR: 1010|0101=1111, 1010|0000=1010, 0000|0000=0000.
- Back-to-back ops with in_valid high every cycle:
  - Each result appears exactly one cycle later.
  - Drop in_valid: outputs hold, out_valid=0.
- Reset: assert rst_n=0 asynchronously between clock edges while out_valid=1 -> result=0, cout=0, out_valid=0 immediately. After release, the first valid op produces a correct result.
